// File: rtl/intl_event_log.sv
// Interlock event logger: detects newly asserted interlock bits and queues them in a FWFT FIFO
// with sticky overflow and first-fault capture. Define INTL_LOG_TIMESTAMP_EN to add 32-bit timestamps.
module intl_event_log #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [15:0]              i_intl_state,
  input  logic                     i_clr,
  input  logic                     i_pop,
  output logic                     o_evt_valid,
  output logic [15:0]              o_evt_state,
  output logic [15:0]              o_evt_new,
  output logic [31:0]              o_evt_time,
  output logic [$clog2(DEPTH):0]   o_fifo_cnt,
  output logic                     o_ovf,
  output logic [15:0]              o_first_fault,
  output logic                     o_first_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [15:0]   r_sQ;
  logic [15:0]   r_prevQ;
  logic [15:0]   r_memState [DEPTH];
  logic [15:0]   r_memNew   [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic [15:0]   r_firstFault;
  logic          r_firstValid;

  logic [15:0]   w_new;
  logic          w_evt;
  logic          w_empty;
  logic          w_full;
  logic          w_popEff;
  logic          w_push;

  // Rising-edge detection only: bits that were already high are never re-logged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sQ    <= '0;
      r_prevQ <= '0;
    end else begin
      r_sQ    <= i_intl_state;
      r_prevQ <= r_sQ;
    end
  end

  assign w_new   = r_sQ & ~r_prevQ;
  assign w_evt   = |w_new;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FullCnt);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_popEff = i_pop & ~w_empty & ~i_clr;
  assign w_push   = w_evt & ~i_clr & (~w_full | w_popEff);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_popEff) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_popEff})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memState[r_wrPtr] <= r_sQ;
      r_memNew[r_wrPtr]   <= w_new;
    end
  end

  // Overflow and first-fault are sticky until clear; clear beats any same-cycle event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf        <= 1'b0;
      r_firstFault <= '0;
      r_firstValid <= 1'b0;
    end else if (i_clr) begin
      r_ovf        <= 1'b0;
      r_firstFault <= '0;
      r_firstValid <= 1'b0;
    end else begin
      if (w_evt && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (w_evt && !r_firstValid) begin
        r_firstFault <= w_new;
        r_firstValid <= 1'b1;
      end
    end
  end

`ifdef INTL_LOG_TIMESTAMP_EN
  logic [31:0] r_tsCnt;
  logic [31:0] r_memTime [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tsCnt <= '0;
    end else begin
      r_tsCnt <= r_tsCnt + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memTime[r_wrPtr] <= r_tsCnt;
    end
  end

  assign o_evt_time = w_empty ? 32'd0 : r_memTime[r_rdPtr];
`else
  assign o_evt_time = 32'd0;
`endif

  assign o_evt_valid   = ~w_empty;
  assign o_evt_state   = w_empty ? 16'd0 : r_memState[r_rdPtr];
  assign o_evt_new     = w_empty ? 16'd0 : r_memNew[r_rdPtr];
  assign o_fifo_cnt    = r_cnt;
  assign o_ovf         = r_ovf;
  assign o_first_fault = r_firstFault;
  assign o_first_valid = r_firstValid;

endmodule
